// File: rtl/rom_loader_pkg.sv
// Shared types and defaults for the ROM boot loader.
// ROM_LOAD_CHKSUM_EN (optional) adds the trailing checksum state LD_CHK.
package rom_loader_pkg;

   typedef enum logic [2:0] {
      LD_IDLE = 3'd0,
      LD_LEN  = 3'd1,
      LD_DATA = 3'd2,
      LD_CHK  = 3'd3,
      LD_ERR  = 3'd4
   } ld_state_t;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;
   localparam int          DEF_MAX_WORDS = 4096;
   localparam logic [7:0]  DEF_MAGIC     = 8'h5A;

   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
      return base + (idx << 2);
   endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM write port of the boot loader.
// master = byte source / ROM side, slave = loader.
interface rom_loader_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        rom_wen;
   logic [31:0] rom_w_addr;
   logic [31:0] rom_w_data;

   modport master (output rx_valid, rx_data,
                   input  rx_ready, rom_wen, rom_w_addr, rom_w_data);
   modport slave  (input  rx_valid, rx_data,
                   output rx_ready, rom_wen, rom_w_addr, rom_w_data);
endinterface

// File: rtl/rom_loader.sv
// Framed byte-stream boot loader: MAGIC, 4-byte LE count N, N LE words, writes into ROM.
// ROM_LOAD_CHKSUM_EN defined: a trailing sum-mod-256 byte is verified before load_done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// LD_IDLE | hunting for MAGIC, other bytes dropped
// LD_LEN  | assembling the 32-bit word count
// LD_DATA | assembling payload words, one ROM write per word
// LD_CHK  | waiting for the checksum byte (checksum build only)
// LD_ERR  | frame aborted, input stalled until err_clr
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int          MAX_WORDS = DEF_MAX_WORDS,
   parameter logic [7:0]  MAGIC     = DEF_MAGIC
) (
   input  logic         clk,
   input  logic         rstn,
   rom_loader_if.slave  bus,
   input  logic         err_clr,
   output logic         core_hold,
   output logic         load_done,
   output logic         load_err
);

   localparam int IDX_W = $clog2(MAX_WORDS + 1);

   ld_state_t        state, state_nxt;
   logic [1:0]       byte_cnt;
   logic [23:0]      asm_buf;
   logic [31:0]      word_cnt;
   logic [IDX_W-1:0] word_idx;
   logic             rom_wen_q;
   logic [31:0]      rom_w_addr_q, rom_w_data_q;
   logic             accept, last_byte;
   logic             start, wr, finish, fault, clear;
   logic [31:0]      full_word;
`ifdef ROM_LOAD_CHKSUM_EN
   logic [7:0]       chk_sum;
`endif

   assign bus.rx_ready   = (state != LD_ERR);
   assign bus.rom_wen    = rom_wen_q;
   assign bus.rom_w_addr = rom_w_addr_q;
   assign bus.rom_w_data = rom_w_data_q;

   assign accept    = bus.rx_valid && bus.rx_ready;
   assign last_byte = accept && (byte_cnt == 2'd3);
   // asm_buf already holds bytes 0..2; the incoming byte completes the word
   assign full_word = {bus.rx_data, asm_buf};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= LD_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      wr        = 1'b0;
      finish    = 1'b0;
      fault     = 1'b0;
      clear     = 1'b0;
      case (state)
         LD_IDLE: begin
            if (accept && (bus.rx_data == MAGIC)) begin
               start     = 1'b1;
               state_nxt = LD_LEN;
            end
         end
         LD_LEN: begin
            if (last_byte) begin
               if (full_word == 32'd0) begin
`ifdef ROM_LOAD_CHKSUM_EN
                  state_nxt = LD_CHK;
`else
                  finish    = 1'b1;
                  state_nxt = LD_IDLE;
`endif
               end else if (full_word > 32'(MAX_WORDS)) begin
                  fault     = 1'b1;
                  state_nxt = LD_ERR;
               end else begin
                  state_nxt = LD_DATA;
               end
            end
         end
         LD_DATA: begin
            if (last_byte) begin
               wr = 1'b1;
               if (32'(word_idx) + 32'd1 == word_cnt) begin
`ifdef ROM_LOAD_CHKSUM_EN
                  state_nxt = LD_CHK;
`else
                  finish    = 1'b1;
                  state_nxt = LD_IDLE;
`endif
               end
            end
         end
`ifdef ROM_LOAD_CHKSUM_EN
         LD_CHK: begin
            if (accept) begin
               if (bus.rx_data == chk_sum) begin
                  finish    = 1'b1;
                  state_nxt = LD_IDLE;
               end else begin
                  fault     = 1'b1;
                  state_nxt = LD_ERR;
               end
            end
         end
`endif
         LD_ERR: begin
            if (err_clr) begin
               clear     = 1'b1;
               state_nxt = LD_IDLE;
            end
         end
         default: state_nxt = LD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         byte_cnt     <= '0;
         asm_buf      <= '0;
         word_cnt     <= '0;
         word_idx     <= '0;
         rom_wen_q    <= 1'b0;
         rom_w_addr_q <= '0;
         rom_w_data_q <= '0;
         core_hold    <= 1'b0;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
      end else begin
         rom_wen_q <= wr;
         if (wr) begin
            rom_w_addr_q <= word_addr(BASE_ADDR, 32'(word_idx));
            rom_w_data_q <= full_word;
            word_idx     <= word_idx + 1'b1;
         end
         if (accept && ((state == LD_LEN) || (state == LD_DATA))) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_buf  <= {bus.rx_data, asm_buf[23:8]};
         end
         if ((state == LD_LEN) && last_byte) word_cnt <= full_word;
         if (start) begin
            byte_cnt  <= '0;
            word_idx  <= '0;
            core_hold <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
         end
         if (finish) begin
            core_hold <= 1'b0;
            load_done <= 1'b1;
         end
         if (fault) load_err <= 1'b1;
         if (clear) begin
            core_hold <= 1'b0;
            load_err  <= 1'b0;
         end
      end
   end

`ifdef ROM_LOAD_CHKSUM_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                              chk_sum <= '0;
      else if (start)                         chk_sum <= '0;
      else if (accept && (state == LD_DATA))  chk_sum <= chk_sum + bus.rx_data;
   end
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table of frames, hand sequences, random frames.
module tb_rom_loader;
   import rom_loader_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam int          MAXW = 4096;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic err_clr = 1'b0;
   logic core_hold, load_done, load_err;

   rom_loader_if bus();

   rom_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .MAGIC(8'h5A)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .bus       (bus.slave),
      .err_clr   (err_clr),
      .core_hold (core_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        hold;
      logic        done;
   } wr_t;

   wr_t         wr_q[$];
   logic [31:0] rom_model [logic [31:0]];
   logic [31:0] pay_q[$];
`ifdef ROM_LOAD_CHKSUM_EN
   logic [7:0]  chk_delta = 8'h00;
`endif

   // ROM-side observer: every cycle with rom_wen high is one write into the ROM
   always @(negedge clk) begin
      if (bus.rom_wen === 1'b1) begin
         wr_q.push_back('{bus.rom_w_addr, bus.rom_w_data, core_hold, load_done});
         rom_model[bus.rom_w_addr] = bus.rom_w_data;
      end
   end

   task automatic drive(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic maybe_gap(input int pct);
      if ($urandom_range(99) < pct) idle($urandom_range(1, 2));
   endtask

   // Sends one frame and checks it against the expected outcome (exp_err, nexp writes).
   task automatic run_frame(input string tag, input int junk, input logic [31:0] len,
                            input bit exp_err, input int nexp, input int gap_pct);
      logic [31:0] w;
      logic [7:0]  jb;
      bit          chk_on;
      int          n;
`ifdef ROM_LOAD_CHKSUM_EN
      logic [7:0]  sum;
      sum    = 8'h00;
      chk_on = 1'b1;
`else
      chk_on = 1'b0;
`endif
      wr_q.delete();
      for (int j = 0; j < junk; j++) begin
         jb = (j == 0) ? 8'h00 : (j == 1) ? 8'hFF : 8'($urandom);
         if (jb == 8'h5A) jb = 8'hA5;
         drive(jb);
      end
      drive(8'h5A);
      check({tag, "_after_magic"}, {29'd0, load_err, load_done, core_hold}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         maybe_gap(gap_pct);
         drive(len[8*k +: 8]);
      end
      if (len <= 32'(MAXW)) begin
         for (int i = 0; i < int'(len); i++) begin
            w = pay_q[i];
            for (int k = 0; k < 4; k++) begin
               maybe_gap(gap_pct);
               drive(w[8*k +: 8]);
`ifdef ROM_LOAD_CHKSUM_EN
               sum = sum + w[8*k +: 8];
`endif
            end
         end
`ifdef ROM_LOAD_CHKSUM_EN
         maybe_gap(gap_pct);
         drive(sum + chk_delta);
`endif
      end
      check({tag, "_status"}, {28'd0, load_err, load_done, core_hold, bus.rx_ready},
            exp_err ? 32'hA : 32'h5);
      idle(1);
      check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(nexp));
      n = (wr_q.size() < nexp) ? wr_q.size() : nexp;
      for (int i = 0; i < n; i++) begin
         check({tag, "_addr"}, wr_q[i].addr, BASE + 32'(4 * i));
         check({tag, "_data"}, wr_q[i].data, pay_q[i]);
         check({tag, "_wr_flags"}, {30'd0, wr_q[i].hold, wr_q[i].done},
               (!chk_on && i == nexp - 1) ? 32'd1 : 32'd2);
      end
      if (exp_err) begin
         err_clr = 1'b1;
         @(negedge clk);
         err_clr = 1'b0;
         check({tag, "_err_clr"}, {28'd0, load_err, load_done, core_hold, bus.rx_ready}, 32'h1);
      end
   endtask

   typedef struct {
      int          junk;
      logic [31:0] len;
      logic [31:0] d0;
      logic [31:0] d1;
      bit          exp_err;
      int          exp_nwr;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int          n;
      logic [31:0] len;
      logic [31:0] w;
      bit          err;

      tbl[0] = '{0, 32'd2,          32'h1234_5678, 32'hCC79_6877, 1'b0, 2};
      tbl[1] = '{2, 32'd0,          32'h0,         32'h0,         1'b0, 0};
      tbl[2] = '{0, 32'd1,          32'h5A5A_5A5A, 32'h0,         1'b0, 1};
      tbl[3] = '{1, 32'd3,          32'h0000_005A, 32'h5A00_0000, 1'b0, 3};
      tbl[4] = '{0, 32'h0000_1001,  32'h0,         32'h0,         1'b1, 0};
      tbl[5] = '{0, 32'hFFFF_FFFF,  32'h0,         32'h0,         1'b1, 0};
      tbl[6] = '{3, 32'h0001_0000,  32'h0,         32'h0,         1'b1, 0};

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("reset_flags", {27'd0, bus.rom_wen, core_hold, load_done, load_err, bus.rx_ready}, 32'h1);
      check("reset_addr", bus.rom_w_addr, 32'h0);
      check("reset_data", bus.rom_w_data, 32'h0);

      for (int t = 0; t < 7; t++) begin
         pay_q.delete();
         for (int i = 0; i < tbl[t].exp_nwr; i++) pay_q.push_back(tbl[t].d0 + 32'(i) * tbl[t].d1);
         run_frame($sformatf("tbl%0d", t), tbl[t].junk, tbl[t].len, tbl[t].exp_err, tbl[t].exp_nwr, 0);
      end

      // abort by reset after 6 payload bytes: word 0 must survive
      pay_q.delete();
      pay_q.push_back(32'h1122_3344);
      pay_q.push_back(32'h5566_7788);
      wr_q.delete();
      drive(8'h5A);
      drive(8'h02); drive(8'h00); drive(8'h00); drive(8'h00);
      drive(8'h44); drive(8'h33); drive(8'h22); drive(8'h11);
      drive(8'h88); drive(8'h77);
      bus.rx_valid = 1'b0;
      rstn = 1'b0;
      #1;
      check("rst_mid_flags", {27'd0, bus.rom_wen, core_hold, load_done, load_err, bus.rx_ready}, 32'h1);
      check("rst_mid_addr", bus.rom_w_addr, 32'h0);
      check("rst_mid_data", bus.rom_w_data, 32'h0);
      check("rst_mid_word0", rom_model.exists(BASE) ? rom_model[BASE] : 32'hDEAD_0000, 32'h1122_3344);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      pay_q.delete();
      pay_q.push_back(32'hA5A5_0F0F);
      run_frame("after_rst", 0, 32'd1, 1'b0, 1, 0);

      // N == MAX_WORDS is accepted; load one word then abort by reset
      wr_q.delete();
      drive(8'h5A);
      drive(8'h00); drive(8'h10); drive(8'h00); drive(8'h00);
      check("maxw_accept", {29'd0, load_err, core_hold, bus.rx_ready}, 32'h3);
      drive(8'h0D); drive(8'hF0); drive(8'hFE); drive(8'hCA);
      idle(1);
      check("maxw_nwr", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) check("maxw_data", wr_q[0].data, 32'hCAFE_F00D);
      check("maxw_not_done", {30'd0, load_done, core_hold}, 32'h1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

`ifdef ROM_LOAD_CHKSUM_EN
      pay_q.delete();
      pay_q.push_back(32'h0403_0201);
      chk_delta = 8'h00;
      run_frame("chk_ok", 0, 32'd1, 1'b0, 1, 0);
      chk_delta = 8'h01;
      run_frame("chk_bad", 0, 32'd1, 1'b1, 1, 0);
      chk_delta = 8'h00;
`endif

      // random frames against the frame-level model
      for (int r = 0; r < 24; r++) begin
         n = $urandom_range(5);
         len = (r % 6 == 5) ? 32'(MAXW + 1 + $urandom_range(2000)) : 32'(n);
         err = (len > 32'(MAXW));
         pay_q.delete();
         if (!err) begin
            for (int i = 0; i < n; i++) begin
               for (int k = 0; k < 4; k++)
                  w[8*k +: 8] = ($urandom_range(3) == 0) ? 8'h5A : 8'($urandom);
               pay_q.push_back(w);
            end
         end
         run_frame($sformatf("rnd%0d", r), $urandom_range(3), len, err, err ? 0 : n, 30);
      end

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
